bsg_dff_reset_rr_writer: RTL and testbench
==========================================

BSG_DFF_RESET_RR_WRITER -- requirements
Module: bsg_dff_reset_rr_writer

Interface
REQ-001 SHALL have parameter width_p, default -1 (must be overridden), meaning the width of the shared register in bits.
REQ-002 SHALL have parameter els_p, default 4, meaning the number of requesters, legal range 2..8.
REQ-003 SHALL have parameter count_width_p, default 16, meaning the width of the write counter.
REQ-004 SHALL have port clk_i, input, 1 bit: the single clock; all state on posedge.
REQ-005 SHALL have port reset_i, input, 1 bit: the reset, asynchronous and active-high.
REQ-006 SHALL have port v_i, input, els_p bits: per-requester write-request valid.
REQ-007 SHALL have port data_i, input, els_p*width_p bits: requester i data in bits [i*width_p +: width_p].
REQ-008 SHALL have port yumi_o, output, els_p bits: one-hot grant; request i is consumed on the posedge where yumi_o[i]=1.
REQ-009 SHALL have port clear_i, input, 1 bit: synchronous clear of the shared register.
REQ-010 SHALL have port data_o, output, width_p bits: the shared register contents.
REQ-011 SHALL have port valid_o, output, 1 bit: set once the register holds written, not cleared, data.
REQ-012 SHALL have port owner_o, output, $clog2(els_p) bits: index of the last requester written.
REQ-013 SHALL have port count_o, output, count_width_p bits: number of committed writes since reset.

Function
REQ-014 SHALL compute yumi_o combinationally from v_i, clear_i and the priority pointer; yumi_o SHALL be at most one-hot and SHALL be 0 when v_i==0.
REQ-015 SHALL grant round-robin: the search starts at pointer ptr_r and proceeds ptr_r, ptr_r+1, ... mod els_p; the first set v_i wins.
REQ-016 SHALL, on a grant to index g, load ptr_r <= (g+1) mod els_p at the posedge; ptr_r SHALL be unchanged when no grant occurs.
REQ-017 SHALL, on a grant to g, load data_o <= data_i[g], owner_o <= g and valid_o <= 1 at the same posedge; write latency is 1 cycle from grant to data_o.
REQ-018 SHALL increment count_o by 1 per grant, wrapping from 2^count_width_p-1 to 0 with no saturation and no flag.
REQ-019 SHALL give clear_i priority: when clear_i=1, yumi_o SHALL be 0 and, at the posedge, data_o <= 0, valid_o <= 0; owner_o, ptr_r and count_o SHALL hold.
REQ-020 SHALL hold data_o, owner_o, valid_o and count_o when no grant and no clear occur.
REQ-021 SHALL not require v_i to stay asserted after dropping without grant; a requester not granted keeps its request by holding v_i and data_i stable.
REQ-022 SHALL guarantee starvation freedom: a continuously asserted v_i[i] is granted within els_p cycles in which clear_i=0.
REQ-023 SHALL leave unused ptr_r encodings (els_p not a power of two) unreachable; on any ptr_r >= els_p the pointer SHALL be treated as 0.
REQ-024 SHALL implement the shared register with bsg_dff_reset-style reset-to-zero semantics, but with the asynchronous reset of REQ-005.

Reset
REQ-025 SHALL, while reset_i=1, asynchronously force data_o=0, valid_o=0, owner_o=0, count_o=0, ptr_r=0, independent of clk_i.
REQ-026 SHALL force yumi_o=0 while reset_i=1, so no request is consumed during reset.
REQ-027 SHALL, after reset_i deasserts, grant on the first posedge where v_i!=0 and clear_i=0.
REQ-028 SHALL abort a write in flight when reset_i asserts in the same cycle as a grant: post-reset state equals REQ-025 values.

Verification
REQ-029 Reset mid-run: width_p=8, els_p=4, after writes reset_i pulsed between edges -> all outputs 0 immediately, before the next posedge.
REQ-030 Round-robin fairness: v_i=4'b1111 held, data_i[i]=8'h10+i, 8 cycles -> yumi_o sequence 0001,0010,0100,1000,0001,...; data_o 8'h10,11,12,13,10,... one cycle later; count_o=8.
REQ-031 Pointer skip: ptr_r=1, v_i=4'b1001 -> yumi_o=4'b1000, then ptr_r=0, next yumi_o=4'b0001; owner_o=3 then 0.
REQ-032 Clear priority: valid_o=1, data_o=8'h5A, clear_i=1 with v_i=4'b0100 -> yumi_o=0, next cycle data_o=0, valid_o=0, owner_o and count_o unchanged; request granted on following cycle.
REQ-033 Counter wrap: count_width_p=4, 17 grants -> count_o reads 15 after 15th grant, 0 after 16th, 1 after 17th.
REQ-034 Non-power-of-two: els_p=3, all requesting for 6 cycles -> grants 0,1,2,0,1,2; yumi_o never wider than one-hot.

Source files
------------

// File: rtl/bsg_dff_reset_rr_writer.sv
// ---------------------------------------------------------------------------
// bsg_dff_reset_rr_writer
//
// Purpose:
//   A single shared register written by els_p requesters. At most one
//   requester is granted per cycle, chosen round-robin from a rotating
//   priority pointer. A granted requester's data is loaded into the shared
//   register at the same posedge. The register also records which requester
//   wrote it last and how many writes have been committed since reset.
//   A synchronous clear empties the register. Clear beats any grant.
//
// Ports:
//   clk_i    in   1              clock, all state on posedge
//   reset_i  in   1              asynchronous, active-high reset
//   v_i      in   els_p          per-requester write request
//   data_i   in   els_p*width_p  requester i data at [i*width_p +: width_p]
//   yumi_o   out  els_p          one-hot grant; request consumed at posedge
//   clear_i  in   1              synchronous clear of the shared register
//   data_o   out  width_p        shared register contents
//   valid_o  out  1              register holds written, not-cleared data
//   owner_o  out  clog2(els_p)   index of the last requester written
//   count_o  out  count_width_p  committed writes since reset (wraps)
//
// Handshake:
//   v_i[i]/yumi_o[i] form a valid/yumi pair. A requester raises v_i[i] with
//   data_i slice i stable. The request is consumed on the posedge where
//   yumi_o[i]=1. A requester may drop v_i at any time without a grant.
//   yumi_o depends combinationally on v_i, so the requester must not make
//   v_i depend on yumi_o.
// ---------------------------------------------------------------------------
module bsg_dff_reset_rr_writer #(
    parameter int width_p       = -1,
    parameter int els_p         = 4,
    parameter int count_width_p = 16,
    // width_p has no usable default, so it is clamped to at least 1 bit.
    // With a legal override, w_lp is the same as width_p.
    localparam int w_lp         = (width_p > 0) ? width_p : 1,
    localparam int ptr_w_lp     = $clog2(els_p)
) (
    input  logic                     clk_i,
    input  logic                     reset_i,
    input  logic [els_p-1:0]         v_i,
    input  logic [els_p*w_lp-1:0]    data_i,
    output logic [els_p-1:0]         yumi_o,
    input  logic                     clear_i,
    output logic [w_lp-1:0]          data_o,
    output logic                     valid_o,
    output logic [ptr_w_lp-1:0]      owner_o,
    output logic [count_width_p-1:0] count_o
);

    // Pointer arithmetic uses one extra bit. This lets a sum of two indices
    // below els_p be compared against els_p without overflow.
    localparam int              pw1_lp = ptr_w_lp + 1;
    localparam logic [pw1_lp-1:0] els_lp = pw1_lp'(els_p);

    logic [ptr_w_lp-1:0]      ptr_r;
    logic [ptr_w_lp-1:0]      ptr_eff;
    logic [ptr_w_lp-1:0]      ptr_next;
    logic [ptr_w_lp-1:0]      grant_idx;
    logic                     grant_found;
    logic                     grant_fire;
    logic [w_lp-1:0]          sel_data;

    logic [w_lp-1:0]          data_r;
    logic                     valid_r;
    logic [ptr_w_lp-1:0]      owner_r;
    logic [count_width_p-1:0] count_r;

    // When els_p is not a power of two, some ptr_r encodings are never
    // loaded. If one appears anyway, the pointer behaves as if it were 0.
    assign ptr_eff = ({1'b0, ptr_r} >= els_lp) ? '0 : ptr_r;

    // Rotating-priority search. Candidates are visited as
    // ptr_eff, ptr_eff+1, ... modulo els_p, and the first set request wins.
    always_comb begin
        logic [pw1_lp-1:0] cand;
        grant_found = 1'b0;
        grant_idx   = '0;
        cand        = '0;
        for (int k = 0; k < els_p; k++) begin
            cand = {1'b0, ptr_eff} + pw1_lp'(k);
            if (cand >= els_lp) begin
                cand = cand - els_lp;
            end
            if (!grant_found && v_i[cand[ptr_w_lp-1:0]]) begin
                grant_found = 1'b1;
                grant_idx   = cand[ptr_w_lp-1:0];
            end
        end
    end

    // Reset and clear both block the grant. This keeps any request from
    // being consumed when no write can commit.
    assign grant_fire = grant_found & ~clear_i & ~reset_i;

    always_comb begin
        yumi_o = '0;
        if (grant_fire) begin
            yumi_o[grant_idx] = 1'b1;
        end
    end

    // Data mux for the winning requester.
    always_comb begin
        sel_data = '0;
        for (int i = 0; i < els_p; i++) begin
            if (grant_idx == ptr_w_lp'(i)) begin
                sel_data = data_i[i*w_lp +: w_lp];
            end
        end
    end

    // After a grant, the winner drops to lowest priority.
    always_comb begin
        logic [pw1_lp-1:0] nxt;
        nxt = {1'b0, grant_idx} + pw1_lp'(1);
        if (nxt >= els_lp) begin
            nxt = '0;
        end
        ptr_next = nxt[ptr_w_lp-1:0];
    end

    // Priority pointer. It moves only on a grant.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            ptr_r <= '0;
        end else if (grant_fire) begin
            ptr_r <= ptr_next;
        end
    end

    // Shared register and its valid flag. Both reset to zero. Clear empties
    // them, and a grant loads them.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            data_r  <= '0;
            valid_r <= 1'b0;
        end else if (clear_i) begin
            data_r  <= '0;
            valid_r <= 1'b0;
        end else if (grant_fire) begin
            data_r  <= sel_data;
            valid_r <= 1'b1;
        end
    end

    // Owner and write count. A clear does not change either of them.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            owner_r <= '0;
            count_r <= '0;
        end else if (grant_fire) begin
            owner_r <= grant_idx;
            count_r <= count_r + 1'b1;
        end
    end

    assign data_o  = data_r;
    assign valid_o = valid_r;
    assign owner_o = owner_r;
    assign count_o = count_r;

endmodule

// File: tb/tb_bsg_dff_reset_rr_writer.sv
// ---------------------------------------------------------------------------
// tb_bsg_dff_reset_rr_writer
//
// Two instances share one clock and one reset:
//   unit 0: width 8, 4 requesters, 4-bit counter (exercises counter wrap)
//   unit 1: width 8, 3 requesters, 16-bit counter (non-power-of-two)
// A reference model tracks the pointer, register, owner and count as plain
// integers and predicts each grant by modular search.
// ---------------------------------------------------------------------------
module tb_bsg_dff_reset_rr_writer;

  // clock / reset
  logic clk_i = 1'b0;
  logic reset_i;
  always #5 clk_i = ~clk_i;

  // unit 0
  logic [3:0]  v_a;
  logic [31:0] d_a;
  logic        c_a;
  logic [3:0]  yumi_a;
  logic [7:0]  data_a;
  logic        valid_a;
  logic [1:0]  owner_a;
  logic [3:0]  count_a;

  // unit 1
  logic [2:0]  v_b;
  logic [23:0] d_b;
  logic        c_b;
  logic [2:0]  yumi_b;
  logic [7:0]  data_b;
  logic        valid_b;
  logic [1:0]  owner_b;
  logic [15:0] count_b;

  bsg_dff_reset_rr_writer #(.width_p(8), .els_p(4), .count_width_p(4)) dut_a (
    .clk_i(clk_i), .reset_i(reset_i), .v_i(v_a), .data_i(d_a), .yumi_o(yumi_a),
    .clear_i(c_a), .data_o(data_a), .valid_o(valid_a), .owner_o(owner_a),
    .count_o(count_a)
  );

  bsg_dff_reset_rr_writer #(.width_p(8), .els_p(3), .count_width_p(16)) dut_b (
    .clk_i(clk_i), .reset_i(reset_i), .v_i(v_b), .data_i(d_b), .yumi_o(yumi_b),
    .clear_i(c_b), .data_o(data_b), .valid_o(valid_b), .owner_o(owner_b),
    .count_o(count_b)
  );

  // scoreboard
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // reference model, indexed by unit
  int         m_els[2]  = '{4, 3};
  int         m_cmod[2] = '{16, 65536};
  int         m_ptr[2];
  int         m_owner[2];
  int         m_count[2];
  int         m_valid[2];
  logic [7:0] m_data[2];

  function automatic int rr_pick(input int ptr, input int els, input logic [3:0] v);
    for (int k = 0; k < els; k++) begin
      if (v[(ptr + k) % els]) return (ptr + k) % els;
    end
    return -1;
  endfunction

  task automatic model_reset();
    for (int u = 0; u < 2; u++) begin
      m_ptr[u] = 0; m_owner[u] = 0; m_count[u] = 0; m_valid[u] = 0; m_data[u] = 8'h00;
    end
  endtask

  task automatic check_outputs(input int u);
    if (u == 0) begin
      check_eq("a_data",  {24'h0, data_a},  {24'h0, m_data[0]});
      check_eq("a_valid", {31'h0, valid_a}, m_valid[0]);
      check_eq("a_owner", {30'h0, owner_a}, m_owner[0]);
      check_eq("a_count", {28'h0, count_a}, m_count[0]);
    end else begin
      check_eq("b_data",  {24'h0, data_b},  {24'h0, m_data[1]});
      check_eq("b_valid", {31'h0, valid_b}, m_valid[1]);
      check_eq("b_owner", {30'h0, owner_b}, m_owner[1]);
      check_eq("b_count", {16'h0, count_b}, m_count[1]);
    end
  endtask

  // driver: one cycle of stimulus on unit u.
  // It applies inputs at negedge and checks the combinational grant. At
  // posedge it advances the model, then checks the registered outputs.
  task automatic drive_cycle(input int u, input logic [3:0] v, input logic [31:0] d, input logic clr);
    int         g;
    logic [3:0] y;
    @(negedge clk_i);
    if (u == 0) begin v_a = v; d_a = d; c_a = clr; end
    else        begin v_b = v[2:0]; d_b = d[23:0]; c_b = clr; end
    #1;
    g = clr ? -1 : rr_pick(m_ptr[u], m_els[u], v);
    y = (u == 0) ? yumi_a : {1'b0, yumi_b};
    check_eq(u == 0 ? "a_yumi" : "b_yumi", {28'h0, y}, (g < 0) ? 32'h0 : (32'h1 << g));
    check_eq(u == 0 ? "a_onehot" : "b_onehot", {31'h0, $onehot0(y)}, 32'h1);
    @(posedge clk_i);
    if (clr) begin
      m_data[u]  = 8'h00;
      m_valid[u] = 0;
    end else if (g >= 0) begin
      m_data[u]  = d[g*8 +: 8];
      m_owner[u] = g;
      m_valid[u] = 1;
      m_ptr[u]   = (g + 1) % m_els[u];
      m_count[u] = (m_count[u] + 1) % m_cmod[u];
    end
    #1;
    check_outputs(u);
  endtask

  task automatic idle_inputs();
    v_a = '0; d_a = '0; c_a = 1'b0;
    v_b = '0; d_b = '0; c_b = 1'b0;
  endtask

  // Holds reset across a posedge with requests raised. Checks that all
  // outputs are zero and that no grant is given.
  task automatic apply_reset();
    @(negedge clk_i);
    v_a = 4'b1111; v_b = 3'b111;
    reset_i = 1'b1;
    #1;
    check_eq("rst_yumi_a", {28'h0, yumi_a}, 32'h0);
    check_eq("rst_yumi_b", {29'h0, yumi_b}, 32'h0);
    @(posedge clk_i);
    #1;
    model_reset();
    check_outputs(0);
    check_outputs(1);
    @(negedge clk_i);
    idle_inputs();
    reset_i = 1'b0;
  endtask

  initial begin
    idle_inputs();
    reset_i = 1'b0;
    model_reset();
    apply_reset();

    // Round-robin fairness with all four requesters active.
    for (int i = 0; i < 8; i++) begin
      drive_cycle(0, 4'b1111, 32'h13121110, 1'b0);
      check_eq("rr_data", {24'h0, data_a}, 32'h10 + (i % 4));
    end
    check_eq("rr_count8", {28'h0, count_a}, 32'd8);

    // Pointer skip: ptr=1, requests 3 and 0 -> 3 wins, then 0.
    drive_cycle(0, 4'b0001, 32'h000000AA, 1'b0);
    drive_cycle(0, 4'b1001, 32'hD30000D0, 1'b0);
    check_eq("skip_owner3", {30'h0, owner_a}, 32'd3);
    drive_cycle(0, 4'b1001, 32'hD30000D0, 1'b0);
    check_eq("skip_owner0", {30'h0, owner_a}, 32'd0);

    // Clear priority over a pending request.
    drive_cycle(0, 4'b0100, 32'h005A0000, 1'b0);
    check_eq("clr_pre_data", {24'h0, data_a}, 32'h5A);
    drive_cycle(0, 4'b0100, 32'h00770000, 1'b1);
    check_eq("clr_data",  {24'h0, data_a},  32'h0);
    check_eq("clr_valid", {31'h0, valid_a}, 32'h0);
    check_eq("clr_owner", {30'h0, owner_a}, 32'd2);
    drive_cycle(0, 4'b0100, 32'h00770000, 1'b0);
    check_eq("clr_after", {24'h0, data_a}, 32'h77);

    // Random traffic with occasional clears.
    for (int i = 0; i < 200; i++) begin
      drive_cycle(0, 4'($urandom_range(0, 15)), $urandom, ($urandom_range(0, 7) == 0));
    end

    // Reset pulsed between edges: outputs go to zero before the next posedge.
    @(negedge clk_i);
    v_a = 4'b1111;
    #2 reset_i = 1'b1;
    #1;
    check_eq("async_data",  {24'h0, data_a},  32'h0);
    check_eq("async_valid", {31'h0, valid_a}, 32'h0);
    check_eq("async_owner", {30'h0, owner_a}, 32'h0);
    check_eq("async_count", {28'h0, count_a}, 32'h0);
    check_eq("async_yumi",  {28'h0, yumi_a},  32'h0);
    @(negedge clk_i);
    reset_i = 1'b0;
    idle_inputs();
    model_reset();
    drive_cycle(0, 4'b1111, 32'h44332211, 1'b0);
    check_eq("post_rst_owner", {30'h0, owner_a}, 32'd0);

    // Counter wrap with a 4-bit counter.
    apply_reset();
    for (int i = 1; i <= 17; i++) begin
      drive_cycle(0, 4'b0001, $urandom, 1'b0);
      if (i == 15) check_eq("wrap15", {28'h0, count_a}, 32'd15);
      if (i == 16) check_eq("wrap16", {28'h0, count_a}, 32'd0);
      if (i == 17) check_eq("wrap17", {28'h0, count_a}, 32'd1);
    end
    @(negedge clk_i);
    idle_inputs();

    // Three requesters: grants 0,1,2,0,1,2.
    apply_reset();
    for (int i = 0; i < 6; i++) begin
      drive_cycle(1, 4'b0111, 32'h00C2C1C0, 1'b0);
      check_eq("els3_owner", {30'h0, owner_b}, i % 3);
    end
    for (int i = 0; i < 150; i++) begin
      drive_cycle(1, 4'($urandom_range(0, 7)), $urandom, ($urandom_range(0, 7) == 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
